// File: rtl/clip_controller.sv
// Clip record/playback sequencer: owns the sample address, per-clip recorded
// lengths and the memory/datapath enables for a bank of clip memories.
module clip_controller #(
   parameter int CLIP_COUNT    = 4,
   parameter int ADDRESS_WIDTH = 17,
   parameter int CLIP_LENGTH   = 100000,
   localparam int SELECT_WIDTH = (CLIP_COUNT > 1) ? $clog2(CLIP_COUNT) : 1,
   localparam int LENGTH_WIDTH = ADDRESS_WIDTH + 1
) (
   input  logic                     clock_i,
   input  logic                     reset_i,
   input  logic                     play_i,
   input  logic                     record_i,
   input  logic                     stop_i,
   input  logic                     loop_i,
   input  logic [SELECT_WIDTH-1:0]  play_clip_i,
   input  logic [SELECT_WIDTH-1:0]  record_clip_i,
   input  logic                     sample_tick_i,
   output logic                     playing_o,
   output logic                     recording_o,
   output logic [SELECT_WIDTH-1:0]  active_clip_o,
   output logic [CLIP_COUNT-1:0]    clip_valid_o,
   output logic [CLIP_COUNT-1:0]    memory_enable_o,
   output logic                     memory_we_o,
   output logic [ADDRESS_WIDTH-1:0] memory_address_o,
   output logic                     serializer_enable_o,
   output logic                     deserializer_enable_o,
   output logic                     rejected_o,
   output logic [1:0]               state_o
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RECORD = 2'd1,
      ST_PLAY   = 2'd2
   } state_t;

   localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR  = ADDRESS_WIDTH'(CLIP_LENGTH - 1);
   localparam logic [LENGTH_WIDTH-1:0]  FULL_LEN   = LENGTH_WIDTH'(CLIP_LENGTH);
   localparam logic [SELECT_WIDTH:0]    CLIP_LIMIT = (SELECT_WIDTH + 1)'(CLIP_COUNT);

   state_t                    state_q, state_d;
   logic [ADDRESS_WIDTH-1:0]  address_q, address_d;
   logic [SELECT_WIDTH-1:0]   active_clip_q, active_clip_d;
   logic [LENGTH_WIDTH-1:0]   play_len_q, play_len_d;
   logic [LENGTH_WIDTH-1:0]   length_q [CLIP_COUNT];
   logic [LENGTH_WIDTH-1:0]   length_d [CLIP_COUNT];
   logic [CLIP_COUNT-1:0]     clip_valid_q, clip_valid_d;
   logic [CLIP_COUNT-1:0]     memory_enable_q, memory_enable_d;
   logic                      playing_q, playing_d;
   logic                      recording_q, recording_d;
   logic                      ser_en_q, ser_en_d;
   logic                      deser_en_q, deser_en_d;
   logic                      rejected_q, rejected_d;

   logic                      record_idx_ok;
   logic                      play_idx_ok;
   logic                      play_end;

   function automatic logic [CLIP_COUNT-1:0] one_hot(input logic [SELECT_WIDTH-1:0] sel);
      logic [CLIP_COUNT-1:0] result;
      result = '0;
      for (int n = 0; n < CLIP_COUNT; n++) begin
         if (sel == SELECT_WIDTH'(n)) result[n] = 1'b1;
      end
      return result;
   endfunction

   assign record_idx_ok = ({1'b0, record_clip_i} < CLIP_LIMIT);
   assign play_idx_ok   = ({1'b0, play_clip_i} < CLIP_LIMIT);
   // Last sample of the clip being played; the LAST_ADDR term keeps the address in range.
   assign play_end      = (({1'b0, address_q} + LENGTH_WIDTH'(1)) == play_len_q) ||
                          (address_q == LAST_ADDR);

   always_comb begin
      state_d       = state_q;
      address_d     = address_q;
      active_clip_d = active_clip_q;
      play_len_d    = play_len_q;
      length_d      = length_q;
      rejected_d    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            address_d = '0;
            if (record_i) begin
               if (record_idx_ok) begin
                  state_d                 = ST_RECORD;
                  active_clip_d           = record_clip_i;
                  length_d[record_clip_i] = '0;
               end else begin
                  rejected_d = 1'b1;
               end
            end else if (play_i) begin
               if (play_idx_ok && (length_q[play_clip_i] != '0)) begin
                  state_d       = ST_PLAY;
                  active_clip_d = play_clip_i;
                  play_len_d    = length_q[play_clip_i];
               end else begin
                  rejected_d = 1'b1;
               end
            end
         end

         ST_RECORD: begin
            if (sample_tick_i && (address_q == LAST_ADDR)) begin
               length_d[active_clip_q] = FULL_LEN;
               state_d                 = ST_IDLE;
               address_d               = '0;
            end else if (stop_i) begin
               // A tick coinciding with stop is still written, so it counts toward the length.
               length_d[active_clip_q] = {1'b0, address_q} + LENGTH_WIDTH'(sample_tick_i);
               state_d                 = ST_IDLE;
               address_d               = '0;
            end else if (sample_tick_i) begin
               address_d = address_q + ADDRESS_WIDTH'(1);
            end
         end

         ST_PLAY: begin
            if (stop_i) begin
               state_d   = ST_IDLE;
               address_d = '0;
            end else if (sample_tick_i) begin
               if (play_end) begin
                  address_d = '0;
                  if (!loop_i) state_d = ST_IDLE;
               end else begin
                  address_d = address_q + ADDRESS_WIDTH'(1);
               end
            end
         end

         default: begin
            state_d   = ST_IDLE;
            address_d = '0;
         end
      endcase

      for (int n = 0; n < CLIP_COUNT; n++) begin
         clip_valid_d[n] = (length_d[n] != '0);
      end

      playing_d       = (state_d == ST_PLAY);
      recording_d     = (state_d == ST_RECORD);
      ser_en_d        = (state_d == ST_PLAY);
      deser_en_d      = (state_d == ST_RECORD);
      memory_enable_d = (state_d == ST_IDLE) ? '0 : one_hot(active_clip_d);
   end

   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
         state_q         <= ST_IDLE;
         address_q       <= '0;
         active_clip_q   <= '0;
         play_len_q      <= '0;
         for (int n = 0; n < CLIP_COUNT; n++) begin
            length_q[n] <= '0;
         end
         clip_valid_q    <= '0;
         memory_enable_q <= '0;
         playing_q       <= 1'b0;
         recording_q     <= 1'b0;
         ser_en_q        <= 1'b0;
         deser_en_q      <= 1'b0;
         rejected_q      <= 1'b0;
      end else begin
         state_q         <= state_d;
         address_q       <= address_d;
         active_clip_q   <= active_clip_d;
         play_len_q      <= play_len_d;
         for (int n = 0; n < CLIP_COUNT; n++) begin
            length_q[n] <= length_d[n];
         end
         clip_valid_q    <= clip_valid_d;
         memory_enable_q <= memory_enable_d;
         playing_q       <= playing_d;
         recording_q     <= recording_d;
         ser_en_q        <= ser_en_d;
         deser_en_q      <= deser_en_d;
         rejected_q      <= rejected_d;
      end
   end

   // Write strobe follows the tick directly so the sample lands in the current address.
   assign memory_we_o           = recording_q & sample_tick_i;
   assign playing_o             = playing_q;
   assign recording_o           = recording_q;
   assign active_clip_o         = active_clip_q;
   assign clip_valid_o          = clip_valid_q;
   assign memory_enable_o       = memory_enable_q;
   assign memory_address_o      = address_q;
   assign serializer_enable_o   = ser_en_q;
   assign deserializer_enable_o = deser_en_q;
   assign rejected_o            = rejected_q;
   assign state_o               = state_q;

endmodule

// File: tb/tb_clip_controller.sv
// Directed bench for clip_controller with a small clip bank (4 clips of 8 samples).
module tb_clip_controller;

   localparam int CC = 4;
   localparam int AW = 3;
   localparam int CL = 8;
   localparam int SW = 2;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_RECORD = 2'd1;
   localparam logic [1:0] S_PLAY   = 2'd2;

   logic          clock_i = 1'b0;
   logic          reset_i;
   logic          play_i, record_i, stop_i, loop_i, sample_tick_i;
   logic [SW-1:0] play_clip_i, record_clip_i;
   logic          playing_o, recording_o, memory_we_o;
   logic          serializer_enable_o, deserializer_enable_o, rejected_o;
   logic [SW-1:0] active_clip_o;
   logic [CC-1:0] clip_valid_o, memory_enable_o;
   logic [AW-1:0] memory_address_o;
   logic [1:0]    state_o;

   logic [AW-1:0] exp_q[$];
   int            checks = 0;
   int            errors = 0;

   clip_controller #(.CLIP_COUNT(CC), .ADDRESS_WIDTH(AW), .CLIP_LENGTH(CL)) dut (
      .clock_i               (clock_i),
      .reset_i               (reset_i),
      .play_i                (play_i),
      .record_i              (record_i),
      .stop_i                (stop_i),
      .loop_i                (loop_i),
      .play_clip_i           (play_clip_i),
      .record_clip_i         (record_clip_i),
      .sample_tick_i         (sample_tick_i),
      .playing_o             (playing_o),
      .recording_o           (recording_o),
      .active_clip_o         (active_clip_o),
      .clip_valid_o          (clip_valid_o),
      .memory_enable_o       (memory_enable_o),
      .memory_we_o           (memory_we_o),
      .memory_address_o      (memory_address_o),
      .serializer_enable_o   (serializer_enable_o),
      .deserializer_enable_o (deserializer_enable_o),
      .rejected_o            (rejected_o),
      .state_o               (state_o)
   );

   always #5 clock_i = ~clock_i;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Returns just after the active edge, with registered outputs settled.
   task automatic cycle();
      @(posedge clock_i);
      #1;
   endtask

   // One sample tick: the popped address and strobe are compared before the edge.
   task automatic do_tick(input logic exp_we, input int gap);
      logic [AW-1:0] exp_addr;
      sample_tick_i = 1'b1;
      #1;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL tick_queue: observed empty queue expected an address");
      end else begin
         exp_addr = exp_q.pop_front();
         check("tick_address", 32'(memory_address_o), 32'(exp_addr));
      end
      check("tick_we", 32'(memory_we_o), 32'(exp_we));
      cycle();
      sample_tick_i = 1'b0;
      repeat (gap) cycle();
   endtask

   task automatic check_idle(input string tag, input logic [CC-1:0] exp_valid);
      check({tag, "_state"}, 32'(state_o), 32'(S_IDLE));
      check({tag, "_playing"}, 32'(playing_o), 32'd0);
      check({tag, "_recording"}, 32'(recording_o), 32'd0);
      check({tag, "_mem_en"}, 32'(memory_enable_o), 32'd0);
      check({tag, "_addr"}, 32'(memory_address_o), 32'd0);
      check({tag, "_ser_deser"}, 32'({serializer_enable_o, deserializer_enable_o}), 32'd0);
      check({tag, "_valid"}, 32'(clip_valid_o), 32'(exp_valid));
   endtask

   initial begin
      reset_i       = 1'b0;
      play_i        = 1'b0;
      record_i      = 1'b0;
      stop_i        = 1'b0;
      loop_i        = 1'b0;
      sample_tick_i = 1'b0;
      play_clip_i   = '0;
      record_clip_i = '0;
      repeat (2) cycle();
      check_idle("reset", 4'b0000);
      check("reset_rejected", 32'(rejected_o), 32'd0);
      reset_i = 1'b1;
      cycle();

      // Full-length recording into clip 2.
      record_clip_i = 2'd2;
      record_i      = 1'b1;
      cycle();
      record_i = 1'b0;
      check("rec2_state", 32'(state_o), 32'(S_RECORD));
      check("rec2_recording", 32'(recording_o), 32'd1);
      check("rec2_deser", 32'(deserializer_enable_o), 32'd1);
      check("rec2_mem_en", 32'(memory_enable_o), 32'b0100);
      check("rec2_active", 32'(active_clip_o), 32'd2);
      check("rec2_we_idle", 32'(memory_we_o), 32'd0);
      for (int i = 0; i < CL; i++) exp_q.push_back(AW'(i));
      for (int i = 0; i < CL; i++) begin
         check("rec2_mem_en_hold", 32'(memory_enable_o), 32'b0100);
         do_tick(1'b1, $urandom_range(0, 1));
      end
      check_idle("rec2_done", 4'b0100);
      check("rec2_queue_empty", 32'(exp_q.size()), 32'd0);

      // Short recording into clip 1, stopped after three samples.
      record_clip_i = 2'd1;
      record_i      = 1'b1;
      cycle();
      record_i = 1'b0;
      check("rec1_mem_en", 32'(memory_enable_o), 32'b0010);
      for (int i = 0; i < 3; i++) exp_q.push_back(AW'(i));
      for (int i = 0; i < 3; i++) do_tick(1'b1, 0);
      stop_i = 1'b1;
      cycle();
      stop_i = 1'b0;
      check_idle("rec1_stop", 4'b0110);

      // One-shot playback of clip 1.
      play_clip_i = 2'd1;
      play_i      = 1'b1;
      cycle();
      play_i = 1'b0;
      check("play1_state", 32'(state_o), 32'(S_PLAY));
      check("play1_playing", 32'(playing_o), 32'd1);
      check("play1_ser", 32'(serializer_enable_o), 32'd1);
      check("play1_mem_en", 32'(memory_enable_o), 32'b0010);
      check("play1_addr", 32'(memory_address_o), 32'd0);
      for (int i = 0; i < 3; i++) exp_q.push_back(AW'(i));
      for (int i = 0; i < 3; i++) do_tick(1'b0, 1);
      check_idle("play1_done", 4'b0110);

      // Looped playback of clip 1.
      loop_i = 1'b1;
      play_i = 1'b1;
      cycle();
      play_i = 1'b0;
      exp_q.push_back(3'd0); exp_q.push_back(3'd1); exp_q.push_back(3'd2);
      exp_q.push_back(3'd0); exp_q.push_back(3'd1); exp_q.push_back(3'd2);
      exp_q.push_back(3'd0);
      for (int i = 0; i < 7; i++) begin
         do_tick(1'b0, 0);
         check("loop_playing", 32'(playing_o), 32'd1);
      end
      check("loop_addr_after", 32'(memory_address_o), 32'd1);
      stop_i = 1'b1;
      cycle();
      stop_i = 1'b0;
      loop_i = 1'b0;
      check_idle("loop_stop", 4'b0110);

      // Play of an empty clip is refused for exactly one cycle.
      play_clip_i = 2'd3;
      play_i      = 1'b1;
      cycle();
      play_i = 1'b0;
      check("empty_rejected", 32'(rejected_o), 32'd1);
      check("empty_playing", 32'(playing_o), 32'd0);
      cycle();
      check("empty_rejected_clear", 32'(rejected_o), 32'd0);
      check("empty_state", 32'(state_o), 32'(S_IDLE));

      // Simultaneous play and record: record wins and invalidates clip 1.
      play_clip_i   = 2'd1;
      record_clip_i = 2'd1;
      play_i        = 1'b1;
      record_i      = 1'b1;
      cycle();
      play_i   = 1'b0;
      record_i = 1'b0;
      check("both_state", 32'(state_o), 32'(S_RECORD));
      check("both_playing", 32'(playing_o), 32'd0);
      check("both_valid", 32'(clip_valid_o), 32'b0100);
      play_i = 1'b1;
      cycle();
      play_i = 1'b0;
      check("busy_play_rejected", 32'(rejected_o), 32'd0);
      check("busy_play_state", 32'(state_o), 32'(S_RECORD));
      for (int i = 0; i < 5; i++) exp_q.push_back(AW'(i));
      for (int i = 0; i < 5; i++) do_tick(1'b1, 0);
      check("pre_reset_addr", 32'(memory_address_o), 32'd5);

      // Asynchronous reset mid-record, checked between edges.
      sample_tick_i = 1'b1;
      #1;
      reset_i = 1'b0;
      #1;
      check_idle("async_reset", 4'b0000);
      check("async_reset_we", 32'(memory_we_o), 32'd0);
      sample_tick_i = 1'b0;
      cycle();
      reset_i = 1'b1;
      cycle();

      // Discarded recording: clip 1 is now empty and play is refused.
      play_clip_i = 2'd1;
      play_i      = 1'b1;
      cycle();
      play_i = 1'b0;
      check("post_reset_rejected", 32'(rejected_o), 32'd1);
      check("post_reset_state", 32'(state_o), 32'(S_IDLE));
      check("final_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/clip_controller.md
CLIP_CONTROLLER -- requirements
Module: clip_controller

Interface
REQ-001 The block SHALL have parameter CLIP_COUNT, default 4, meaning the number of independent clip memories (at least 2).
REQ-002 The block SHALL have parameter ADDRESS_WIDTH, default 17, meaning the sample address width.
REQ-003 The block SHALL have parameter CLIP_LENGTH, default 100000, meaning the maximum samples per clip (at most 2**ADDRESS_WIDTH).
REQ-004 The block SHALL use SELECT_WIDTH = max(1, clog2(CLIP_COUNT)) and LENGTH_WIDTH = ADDRESS_WIDTH+1 as derived widths.
REQ-005 The block SHALL have one clock and an asynchronous active-low reset: clock_i  input  1  system clock, rising edge; reset_i  input  1  asynchronous, active-low reset.
REQ-006 play_i  input  1  single-cycle play command pulse, already synchronised.
REQ-007 record_i  input  1  single-cycle record command pulse, already synchronised.
REQ-008 stop_i  input  1  single-cycle stop command pulse.
REQ-009 loop_i  input  1  level; when high, playback wraps at end of clip.
REQ-010 play_clip_i  input  SELECT_WIDTH  clip index for play.
REQ-011 record_clip_i  input  SELECT_WIDTH  clip index for record.
REQ-012 sample_tick_i  input  1  single-cycle pulse, one per sample period, from serializer/deserializer done.
REQ-013 playing_o, recording_o  output  1 each  operation status.
REQ-014 active_clip_o  output  SELECT_WIDTH  clip index of the current or last operation.
REQ-015 clip_valid_o  output  CLIP_COUNT  bit n high when clip n holds a recorded length greater than 0.
REQ-016 memory_enable_o  output  CLIP_COUNT  one-hot enable of the selected clip memory.
REQ-017 memory_we_o  output  1  write strobe.
REQ-018 memory_address_o  output  ADDRESS_WIDTH  sample address.
REQ-019 serializer_enable_o, deserializer_enable_o  output  1 each  datapath enables.
REQ-020 rejected_o  output  1  single-cycle pulse when a command is refused.

Function
REQ-021 The block SHALL implement the states IDLE, RECORD, PLAY; all outputs SHALL be registered except memory_we_o.
REQ-022 In IDLE, a record_i pulse SHALL move the block to RECORD on the next edge, latch record_clip_i, and zero the address; record_i SHALL win over a simultaneous play_i.
REQ-023 In IDLE, a play_i pulse SHALL move the block to PLAY with address 0 when the latched clip length is nonzero; otherwise the block SHALL stay in IDLE and pulse rejected_o.
REQ-024 A clip index at or above CLIP_COUNT SHALL be rejected with a rejected_o pulse.
REQ-025 play_i and record_i SHALL be ignored outside IDLE, with no rejected_o pulse.
REQ-026 In RECORD: recording_o=1, deserializer_enable_o=1, and memory_enable_o one-hot on the latched clip.
REQ-027 In RECORD, memory_we_o SHALL equal sample_tick_i combinationally, and the address SHALL increment on the edge following each tick.
REQ-028 A RECORD tick at address CLIP_LENGTH-1 SHALL write that sample, store length=CLIP_LENGTH, and return to IDLE.
REQ-029 stop_i in RECORD SHALL store length=current address and return to IDLE; a tick on the same cycle SHALL be written and counted.
REQ-030 A new recording SHALL invalidate the clip's old length on entry to RECORD: length 0, clip_valid_o bit low.
REQ-031 In PLAY: playing_o=1, serializer_enable_o=1, memory_enable_o one-hot, and memory_we_o=0.
REQ-032 In PLAY, the address SHALL increment on each tick.
REQ-033 A PLAY tick at address length-1 SHALL wrap the address to 0 when loop_i=1; otherwise the block SHALL return to IDLE.
REQ-034 stop_i in PLAY SHALL return the block to IDLE on the next edge.
REQ-035 In IDLE, memory_enable_o, memory_we_o and both datapath enables SHALL be 0, and the address SHALL hold 0.
REQ-036 Per-clip lengths SHALL be LENGTH_WIDTH registers.
REQ-037 Address arithmetic SHALL never exceed CLIP_LENGTH-1.

Reset
REQ-038 reset_i low SHALL immediately force IDLE, all outputs 0, all clip lengths 0 and the address 0, including mid-record and mid-play.
REQ-039 A partial recording interrupted by reset SHALL be discarded.

Verification (CLIP_COUNT=4, ADDRESS_WIDTH=3, CLIP_LENGTH=8)
REQ-040 The bench SHALL check: record_i with clip 2, then 8 ticks -> memory_we_o pulses at addresses 0..7, enable 4'b0100, then IDLE with clip_valid_o=4'b0100.
REQ-041 The bench SHALL check: record clip 1, stop_i after 3 ticks, then play clip 1 with loop_i=0 -> reads addresses 0,1,2, then IDLE.
REQ-042 The bench SHALL check: play clip 1 (length 3) with loop_i=1 over 7 ticks -> addresses 0,1,2,0,1,2,0 and playing_o held high.
REQ-043 The bench SHALL check: play_i on empty clip 3 -> rejected_o for one cycle and playing_o stays 0.
REQ-044 The bench SHALL check: play_i and record_i on the same cycle -> RECORD entered.
REQ-045 The bench SHALL check: reset_i low during RECORD at address 5 -> outputs 0 at once and clip_valid_o=0.
